// File: rtl/traffic_lights_pkg.sv
// Shared types and command codes for the multi-approach traffic light controller.
package traffic_lights_pkg;

    typedef enum logic [2:0] {
        ST_ALL_RED     = 3'd0,
        ST_RED_YEL     = 3'd1,
        ST_GREEN       = 3'd2,
        ST_GREEN_BLINK = 3'd3,
        ST_YELLOW      = 3'd4,
        ST_FREE_BLINK  = 3'd5,
        ST_OFF         = 3'd6
    } tl_state_e;

    localparam logic [2:0] CMD_ON     = 3'd0;
    localparam logic [2:0] CMD_OFF    = 3'd1;
    localparam logic [2:0] CMD_FREE   = 3'd2;
    localparam logic [2:0] CMD_GREEN  = 3'd3;
    localparam logic [2:0] CMD_CLEAR  = 3'd4;
    localparam logic [2:0] CMD_YELLOW = 3'd5;

    // A programmed time of zero would make a state vanish, so it is served as 1 ms.
    function automatic logic [15:0] eff_ms(input logic [15:0] ms);
        return (ms == 16'd0) ? 16'd1 : ms;
    endfunction

endpackage

// File: rtl/traffic_lights_multi_blink.sv
// Restartable square-wave generator: phase starts at 1 and toggles every HALF_CYC cycles.
module tl_blink_gen #(
    parameter int HALF_CYC = 4
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic restart_i,
    output logic phase_o
);

    localparam int W = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam logic [W-1:0] RELOAD = W'(HALF_CYC - 1);

    logic [W-1:0] cnt_q;
    logic         phase_q;

    // Half-period counter and phase toggle
    always_ff @(posedge clk_i) begin
        if (srst_i || restart_i) begin
            cnt_q   <= RELOAD;
            phase_q <= 1'b1;
        end else if (cnt_q == '0) begin
            cnt_q   <= RELOAD;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q - W'(1);
            phase_q <= phase_q;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/traffic_lights_multi.sv
// Multi-approach traffic light controller: one approach served at a time,
// programmable green/yellow/clear times, free-blink and off modes.
module traffic_lights_multi
    import traffic_lights_pkg::*;
#(
    parameter int N_DIR          = 2,
    parameter int CLK_PER_MS     = 2,
    parameter int BLINK_HALF_MS  = 50,
    parameter int RED_YEL_MS     = 50,
    parameter int GREEN_BLINK_MS = 5,
    parameter int DEF_GREEN_MS   = 10,
    parameter int DEF_YELLOW_MS  = 5,
    parameter int DEF_CLEAR_MS   = 10
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic [2:0]                 cmd_type_i,
    input  logic                       cmd_valid_i,
    input  logic [15:0]                cmd_data_i,
    output logic [N_DIR-1:0]           red_o,
    output logic [N_DIR-1:0]           yellow_o,
    output logic [N_DIR-1:0]           green_o,
    output logic [$clog2(N_DIR)-1:0]   active_dir_o
);

    localparam int DIR_W = $clog2(N_DIR);
    localparam int CNT_W = 16 + $clog2(CLK_PER_MS + 1);

    function automatic logic [CNT_W-1:0] load_val(input logic [15:0] ms);
        return CNT_W'(eff_ms(ms)) * CNT_W'(CLK_PER_MS) - CNT_W'(1);
    endfunction

    tl_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic [15:0]      green_ms_q, yellow_ms_q, clear_ms_q;
    logic             blink_s;
    logic             blink_restart_s;
    logic [N_DIR-1:0] sel_s;

    // State, phase counter and served approach
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= ST_ALL_RED;
            cnt_q   <= load_val(16'(DEF_CLEAR_MS));
            dir_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // Programmable times; only sampled at state entry, so the running phase is unaffected
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            green_ms_q  <= 16'(DEF_GREEN_MS);
            yellow_ms_q <= 16'(DEF_YELLOW_MS);
            clear_ms_q  <= 16'(DEF_CLEAR_MS);
        end else if (cmd_valid_i) begin
            case (cmd_type_i)
                CMD_GREEN:  green_ms_q  <= cmd_data_i;
                CMD_CLEAR:  clear_ms_q  <= cmd_data_i;
                CMD_YELLOW: yellow_ms_q <= cmd_data_i;
                default:    green_ms_q  <= green_ms_q;
            endcase
        end
    end

    // Next-state: mode commands take priority over the timed normal cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (cmd_valid_i && cmd_type_i == CMD_OFF) begin
            state_d = ST_OFF;
        end else if (cmd_valid_i && cmd_type_i == CMD_FREE) begin
            state_d = ST_FREE_BLINK;
        end else if (cmd_valid_i && cmd_type_i == CMD_ON &&
                     (state_q == ST_OFF || state_q == ST_FREE_BLINK)) begin
            state_d = ST_ALL_RED;
            cnt_d   = load_val(clear_ms_q);
        end else if (state_q == ST_OFF || state_q == ST_FREE_BLINK) begin
            state_d = state_q;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            case (state_q)
                ST_ALL_RED: begin
                    state_d = ST_RED_YEL;
                    dir_d   = (dir_q == DIR_W'(N_DIR - 1)) ? '0 : dir_q + DIR_W'(1);
                    cnt_d   = load_val(16'(RED_YEL_MS));
                end
                ST_RED_YEL: begin
                    state_d = ST_GREEN;
                    cnt_d   = load_val(green_ms_q);
                end
                ST_GREEN: begin
                    state_d = ST_GREEN_BLINK;
                    cnt_d   = load_val(16'(GREEN_BLINK_MS));
                end
                ST_GREEN_BLINK: begin
                    state_d = ST_YELLOW;
                    cnt_d   = load_val(yellow_ms_q);
                end
                ST_YELLOW: begin
                    state_d = ST_ALL_RED;
                    cnt_d   = load_val(clear_ms_q);
                end
                default: begin
                    state_d = ST_ALL_RED;
                    cnt_d   = load_val(clear_ms_q);
                end
            endcase
        end
    end

    assign blink_restart_s = (state_d != state_q) &&
                             (state_d == ST_GREEN_BLINK || state_d == ST_FREE_BLINK);

    tl_blink_gen #(
        .HALF_CYC (BLINK_HALF_MS * CLK_PER_MS)
    ) u_blink (
        .clk_i     (clk_i),
        .srst_i    (srst_i),
        .restart_i (blink_restart_s),
        .phase_o   (blink_s)
    );

    assign sel_s        = N_DIR'(1) << dir_q;
    assign active_dir_o = dir_q;

    // Lamp decode from registered state, approach and blink phase
    always_comb begin
        red_o    = '0;
        yellow_o = '0;
        green_o  = '0;
        case (state_q)
            ST_ALL_RED:     red_o = '1;
            ST_RED_YEL: begin
                red_o    = '1;
                yellow_o = sel_s;
            end
            ST_GREEN: begin
                red_o   = ~sel_s;
                green_o = sel_s;
            end
            ST_GREEN_BLINK: begin
                red_o   = ~sel_s;
                green_o = sel_s & {N_DIR{blink_s}};
            end
            ST_YELLOW: begin
                red_o    = ~sel_s;
                yellow_o = sel_s;
            end
            ST_FREE_BLINK:  yellow_o = {N_DIR{blink_s}};
            ST_OFF:         red_o = '0;
            default:        red_o = '1;
        endcase
    end

endmodule

// File: tb/tb_traffic_lights_multi.sv
// Self-checking bench: directed table, corner-case sequences and random commands vs a phase-level model.
module tb_traffic_lights_multi;

    localparam int N_DIR = 2, CPM = 2, BH = 2, RY = 3, GB = 4;
    localparam int DG = 10, DY = 5, DC = 10;
    localparam int H = BH * CPM;
    localparam int P_RY = 0, P_G = 1, P_GB = 2, P_Y = 3, P_AR = 4, P_FREE = 5, P_OFF = 6;

    logic        clk = 1'b0;
    logic        srst = 1'b0, valid = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic [15:0] data = 16'd0;
    logic [1:0]  red, yel, grn;
    logic [0:0]  dir;

    always #5 clk = ~clk;

    traffic_lights_multi #(
        .N_DIR(N_DIR), .CLK_PER_MS(CPM), .BLINK_HALF_MS(BH), .RED_YEL_MS(RY),
        .GREEN_BLINK_MS(GB), .DEF_GREEN_MS(DG), .DEF_YELLOW_MS(DY), .DEF_CLEAR_MS(DC)
    ) dut (
        .clk_i(clk), .srst_i(srst), .cmd_type_i(cmd), .cmd_valid_i(valid),
        .cmd_data_i(data), .red_o(red), .yellow_o(yel), .green_o(grn),
        .active_dir_o(dir)
    );

    int n_vec = 0, n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase name, cycles left in phase, served approach, cycles since blink start
    int m_ph, m_left, m_dir, m_age, m_green, m_yellow, m_clear;

    function automatic int eff(input int ms);
        return (ms == 0) ? 1 : ms;
    endfunction

    function automatic int dur(input int p);
        case (p)
            P_RY:    return RY * CPM;
            P_G:     return eff(m_green) * CPM;
            P_GB:    return GB * CPM;
            P_Y:     return eff(m_yellow) * CPM;
            default: return eff(m_clear) * CPM;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit v, input int c, input int d);
        int prev;
        if (r) begin
            m_ph = P_AR; m_dir = 0; m_age = 0;
            m_green = DG; m_yellow = DY; m_clear = DC;
            m_left = DC * CPM;
            return;
        end
        prev = m_ph;
        if (v && c == 1) m_ph = P_OFF;
        else if (v && c == 2) m_ph = P_FREE;
        else if (v && c == 0 && (m_ph == P_OFF || m_ph == P_FREE)) begin
            m_ph = P_AR;
            m_left = dur(P_AR);
        end else if (m_ph <= P_AR) begin
            m_left--;
            if (m_left == 0) begin
                if (m_ph == P_AR) begin
                    m_dir = (m_dir + 1) % N_DIR;
                    m_ph = P_RY;
                end else m_ph++;
                m_left = dur(m_ph);
            end
        end
        if ((m_ph == P_GB || m_ph == P_FREE) && m_ph != prev) m_age = 0;
        else m_age++;
        if (v) begin
            case (c)
                3: m_green = d;
                4: m_clear = d;
                5: m_yellow = d;
                default: ;
            endcase
        end
    endtask

    task automatic model_lamps(output int r, output int y, output int g);
        int sel, blink;
        sel = 1 << m_dir;
        blink = ((m_age / H) % 2 == 0) ? 1 : 0;
        r = 0; y = 0; g = 0;
        case (m_ph)
            P_AR:   r = 3;
            P_RY:   begin r = 3; y = sel; end
            P_G:    begin r = 3 - sel; g = sel; end
            P_GB:   begin r = 3 - sel; g = blink ? sel : 0; end
            P_Y:    begin r = 3 - sel; y = sel; end
            P_FREE: y = blink ? 3 : 0;
            default: ;
        endcase
    endtask

    task automatic tick(input bit r, input bit v, input int c, input int d);
        int er, ey, eg;
        @(negedge clk);
        srst = r; valid = v; cmd = 3'(c); data = 16'(d);
        @(posedge clk);
        model_step(r, v, c, d);
        #1;
        srst = 1'b0; valid = 1'b0;
        model_lamps(er, ey, eg);
        check("model_red", red, er);
        check("model_yellow", yel, ey);
        check("model_green", grn, eg);
        check("model_dir", dir, m_dir);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 0, 0);
    endtask

    // Counts consecutive cycles (from the current one) where the lamps match a pattern
    task automatic run_len(input int mode, output int n);
        n = 0;
        while (n < 300) begin
            if (mode == 0 && grn == 2'b00) break;
            if (mode == 1 && !(red == 2'b11 && yel == 2'b00)) break;
            n++;
            idle(1);
        end
    endtask

    // Advances until a pattern appears; 0 green on, 1 all-red, 2 yellow state
    task automatic wait_for(input int mode, input string name);
        int k;
        k = 0;
        while (k < 300) begin
            if (mode == 0 && grn != 2'b00) break;
            if (mode == 1 && red == 2'b11 && yel == 2'b00) break;
            if (mode == 2 && yel != 2'b00 && red != 2'b11) break;
            k++;
            idle(1);
        end
        if (k >= 300) begin
            n_vec++; n_err++;
            $display("FAIL %s: timeout after %0d cycles", name, k);
        end
    endtask

    typedef struct {
        bit rst; bit v; int c; int d; int adv;
        int er; int ey; int eg; int ed;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // rst, v, c, d, adv, red, yel, grn, dir
        tbl[0]  = '{1, 0, 0, 0, 0,  3, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 19, 3, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 1,  3, 2, 0, 1};
        tbl[3]  = '{0, 0, 0, 0, 5,  3, 2, 0, 1};
        tbl[4]  = '{0, 0, 0, 0, 1,  1, 0, 2, 1};
        tbl[5]  = '{0, 0, 0, 0, 19, 1, 0, 2, 1};
        tbl[6]  = '{0, 0, 0, 0, 1,  1, 0, 2, 1};
        tbl[7]  = '{0, 0, 0, 0, 3,  1, 0, 2, 1};
        tbl[8]  = '{0, 0, 0, 0, 1,  1, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 3,  1, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 1,  1, 2, 0, 1};
        tbl[11] = '{0, 0, 0, 0, 9,  1, 2, 0, 1};
        tbl[12] = '{0, 0, 0, 0, 1,  3, 0, 0, 1};
        tbl[13] = '{0, 0, 0, 0, 19, 3, 0, 0, 1};
        tbl[14] = '{0, 0, 0, 0, 1,  3, 1, 0, 0};

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].rst) tick(1'b1, 1'b0, 0, 0);
            else if (tbl[i].v) tick(1'b0, 1'b1, tbl[i].c, tbl[i].d);
            idle(tbl[i].adv);
            check($sformatf("tbl%0d_red", i), red, tbl[i].er);
            check($sformatf("tbl%0d_yellow", i), yel, tbl[i].ey);
            check($sformatf("tbl%0d_green", i), grn, tbl[i].eg);
            check($sformatf("tbl%0d_dir", i), dir, tbl[i].ed);
        end

        // Reprogrammed green applies only to the next green phase
        idle(6);
        check("green_entry", grn, 1);
        tick(1'b0, 1'b1, 3, 7);
        run_len(0, n);
        check("green_run_unchanged", n, 23);
        wait_for(0, "wait_next_green");
        check("next_green_dir", dir, 1);
        run_len(0, n);
        check("green_run_reprog", n, 18);

        // Free blink from green, then back on via all-red
        wait_for(0, "wait_green_free");
        tick(1'b0, 1'b1, 2, 0);
        check("free_yellow_on", yel, 3);
        check("free_red_off", red, 0);
        check("free_green_off", grn, 0);
        idle(4);
        check("free_yellow_off", yel, 0);
        idle(4);
        check("free_yellow_again", yel, 3);
        tick(1'b0, 1'b1, 0, 0);
        check("on_all_red", red, 3);
        check("on_dir_kept", dir, 0);
        run_len(1, n);
        check("on_clear_len", n, 20);
        check("resume_red_yel", yel, 2);
        check("resume_dir", dir, 1);

        // Off, on, and a zero clear time served as 1 ms
        tick(1'b0, 1'b1, 2, 0);
        tick(1'b0, 1'b1, 1, 0);
        check("off_red", red, 0);
        check("off_yellow", yel, 0);
        check("off_green", grn, 0);
        tick(1'b0, 1'b1, 0, 0);
        check("off_on_red", red, 3);
        tick(1'b0, 1'b1, 4, 0);
        run_len(1, n);
        check("clear_run_unchanged", n, 19);
        wait_for(1, "wait_next_clear");
        run_len(1, n);
        check("clear_zero_len", n, 2);

        // Reset mid-yellow overrides a simultaneous OFF
        wait_for(2, "wait_yellow");
        tick(1'b1, 1'b1, 1, 0);
        check("rst_red", red, 3);
        check("rst_yellow", yel, 0);
        check("rst_green", grn, 0);
        check("rst_dir", dir, 0);
        idle(1);
        check("rst_after_red", red, 3);

        // Random commands and occasional resets against the model
        repeat (1500) begin
            bit r, v;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 7) == 0);
            tick(r, v, int'($urandom_range(0, 7)), int'($urandom_range(0, 12)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
